// File: rtl/rat_io_bridge.sv
// rat_io_bridge: CPU I/O port decoder with output latches, a TX byte queue and a 4-source edge interrupt controller.
// Optional feature macro RAT_IO_TXFIFO_EN: FIFO_DEPTH-entry TX FIFO; when undefined a single holding register is used.
module rat_io_bridge #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter logic [7:0]  OUT_BASE_ID    = 8'h10,
    parameter logic [7:0]  IN_BASE_ID     = 8'h20,
    parameter logic [7:0]  FIFO_PORT_ID   = 8'h40,
    parameter logic [7:0]  STATUS_PORT_ID = 8'h41,
    parameter logic [7:0]  IRQ_PEND_ID    = 8'h42,
    parameter logic [7:0]  IRQ_MASK_ID    = 8'h43
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  port_id,
    input  logic [7:0]  out_port,
    input  logic        io_strb,
    output logic [7:0]  in_port,
    output logic [31:0] out_regs,
    input  logic [31:0] ext_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [3:0]  irq_src,
    output logic        irq_out
);

    logic [7:0]  out_off;
    logic [7:0]  in_off;
    logic        out_hit;
    logic        in_hit;
    logic        push;
    logic        pop;
    logic        status_wr;
    logic        pend_wr;
    logic        mask_wr;
    logic        full;
    logic        empty;
    logic        accept;
    logic        drop;
    logic        overflow;
    logic [31:0] ext_s1;
    logic [31:0] ext_s2;
    logic [3:0]  src_s1;
    logic [3:0]  src_s2;
    logic [3:0]  src_s3;
    logic [3:0]  irq_rise;
    logic [3:0]  pending;
    logic [3:0]  mask;

    // Offsets wrap below the base, so a single unsigned compare decodes each 4-ID window
    assign out_off   = port_id - OUT_BASE_ID;
    assign in_off    = port_id - IN_BASE_ID;
    assign out_hit   = out_off < 8'd4;
    assign in_hit    = in_off < 8'd4;
    assign push      = io_strb && (port_id == FIFO_PORT_ID);
    assign status_wr = io_strb && (port_id == STATUS_PORT_ID);
    assign pend_wr   = io_strb && (port_id == IRQ_PEND_ID);
    assign mask_wr   = io_strb && (port_id == IRQ_MASK_ID);
    assign pop       = tx_valid && tx_ready;
    assign irq_rise  = src_s2 & ~src_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_regs <= '0;
        end else if (io_strb && out_hit) begin
            out_regs[{out_off[1:0], 3'b000} +: 8] <= out_port;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_s1 <= '0;
            ext_s2 <= '0;
            src_s1 <= '0;
            src_s2 <= '0;
            src_s3 <= '0;
        end else begin
            ext_s1 <= ext_in;
            ext_s2 <= ext_s1;
            src_s1 <= irq_src;
            src_s2 <= src_s1;
            src_s3 <= src_s2;
        end
    end

    // A newly detected edge beats a W1C clear of the same bit
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            mask    <= '0;
            irq_out <= 1'b0;
        end else begin
            pending <= (pending & ~(pend_wr ? out_port[3:0] : 4'b0000)) | irq_rise;
            if (mask_wr) begin
                mask <= out_port[3:0];
            end
            irq_out <= |(pending & mask);
        end
    end

`ifdef RAT_IO_TXFIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign accept   = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign tx_valid = !empty;
    assign tx_data  = mem[rd_ptr];

    // When full with a pop, the write lands in the slot being vacated this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem[wr_ptr] <= out_port;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (!accept && pop) begin
                count <= count - 1'b1;
            end
        end
    end
`else
    logic [7:0] hold_data;
    logic       hold_valid;

    assign full     = hold_valid;
    assign empty    = !hold_valid;
    assign accept   = push && (!hold_valid || pop);
    assign drop     = push && hold_valid && !pop;
    assign tx_valid = hold_valid;
    assign tx_data  = hold_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_data  <= out_port;
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (status_wr) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        in_port = 8'h00;
        if (in_hit) begin
            in_port = ext_s2[{in_off[1:0], 3'b000} +: 8];
        end else if (port_id == STATUS_PORT_ID) begin
            in_port = {pending, 1'b0, overflow, full, empty};
        end else if (port_id == IRQ_PEND_ID) begin
            in_port = {4'b0000, pending};
        end else if (port_id == IRQ_MASK_ID) begin
            in_port = {4'b0000, mask};
        end
    end

endmodule
